pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter stage of the single-cycle datapath. It holds the architectural PC and consumes the branch decision (branchsel) plus the control-unit jump, halt and stall signals.
- Each cycle it selects the next PC: sequential, PC-relative branch/jump, or register jump.
- It also runs a small boot/run/halt state machine and drives the instruction-memory address.

Parameters:
- PC_W, 32, PC and target width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- INC, 4, byte increment for the sequential PC; must be a power of two.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold the PC and state this cycle; ignored in BOOT.
- branchsel  input  1  branch-taken decision from the branch unit.
- jump  input  1  PC-relative unconditional jump (J/JAL).
- jump_reg  input  1  register-indirect jump (JR/JALR).
- halt  input  1  HALT instruction decoded.
- resume  input  1  leave HALT (external/debug).
- br_offset  input  PC_W  sign-extended byte offset for branches.
- jmp_offset  input  PC_W  sign-extended byte offset for jump.
- reg_target  input  PC_W  register value for jump_reg.
- pc  output  PC_W  current PC, registered; the instruction-memory address.
- pc_next_seq  output  PC_W  combinational pc+INC; used as the link value.
- instr_valid  output  1  registered; 1 when pc addresses an instruction to execute.
- halted  output  1  registered; 1 in HALT.
- redirect  output  1  registered one-cycle pulse; the previous update was non-sequential.

Behaviour:
- Reset (rst=1 at an edge): pc=RESET_PC, state=BOOT, instr_valid=0, halted=0, redirect=0. This overrides everything, including reset in the middle of HALT or stall.
- States: BOOT, RUN, HALT.
- BOOT: lasts exactly one cycle and lets instruction memory settle.
  - pc is held; stall is ignored.
  - Next state is RUN with instr_valid=1; pc is unchanged (first fetch at RESET_PC).
- RUN with stall=1: pc, state and instr_valid are held; redirect=0.
- RUN with stall=0, next-PC priority (highest first):
  - halt: pc held, state becomes HALT, halted=1, instr_valid=0.
  - jump_reg: pc = reg_target with bits [log2(INC)-1:0] forced to 0; redirect=1.
  - jump: pc = pc+INC+jmp_offset, low bits forced to 0; redirect=1.
  - branchsel: pc = pc+INC+br_offset, low bits forced to 0; redirect=1.
  - otherwise: pc = pc+INC; redirect=0.
- Arithmetic: all additions are modulo 2^PC_W; wrap-around from all-ones to 0 is legal and silent. Offsets are two's complement; there is no overflow detection.
- Simultaneous requests follow the priority order above. Example: halt+branchsel together gives HALT, and the branch is discarded.
- HALT:
  - pc held, instr_valid=0, halted=1; stall is ignored.
  - resume=1 leads next cycle to RUN, pc = pc+INC (the instruction after HALT), halted=0, instr_valid=1, redirect=0.
  - halt/jump/branch inputs are ignored while halted.
- redirect is 0 in every cycle except the one immediately after a taken non-sequential update.
- pc_next_seq = pc+INC at all times, including during reset/BOOT.
- Latency: the decision on cycle N is visible on pc at cycle N+1.

Optional Feature:
- Macro PC_BRANCH_STATS_EN.
- When defined, two extra output ports are present:
  - taken_cnt [15:0]: counts RUN, stall=0 cycles with branchsel=1 and no higher-priority request.
  - instr_cnt [15:0]: counts RUN, stall=0 cycles (retired instructions, including the halt cycle).
- Both counters saturate at 16'hFFFF and clear on rst.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, no control inputs -> BOOT one cycle at pc=0, instr_valid=0; then pc 0,4,8,12 on successive cycles; redirect=0 throughout.
- At pc=0x10, branchsel=1, br_offset=0xFFFF_FFF0 -> next pc=0x04, redirect=1 for exactly one cycle, then pc=0x08.
- At pc=0x20, jump_reg=1, jump=1, branchsel=1, reg_target=0x0000_0103 -> next pc=0x100 (jump_reg wins, low bits cleared).
- stall=1 for 3 cycles at pc=0x40 with branchsel=1 -> pc stays 0x40; on the first stall=0 cycle with branchsel still 1 and br_offset=8 -> pc=0x4C.
- At pc=0x50, halt=1 with branchsel=1 -> pc=0x50, halted=1, instr_valid=0 for 5 cycles; resume=1 -> pc=0x54, halted=0; rst asserted while halted -> pc=RESET_PC, state BOOT.
- pc=0xFFFF_FFFC sequential -> pc=0x0000_0000. With PC_BRANCH_STATS_EN: 3 taken branches in 10 run cycles -> taken_cnt=3, instr_cnt=10.

Source files
------------

// File: rtl/pc_seq_if.sv
// Control and PC bus between the decode/branch logic and pc_sequencer.
interface pc_seq_if #(
  parameter int PC_W = 32
);
  logic            stall;
  logic            branchsel;
  logic            jump;
  logic            jump_reg;
  logic            halt;
  logic            resume;
  logic [PC_W-1:0] br_offset;
  logic [PC_W-1:0] jmp_offset;
  logic [PC_W-1:0] reg_target;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next_seq;
  logic            instr_valid;
  logic            halted;
  logic            redirect;

  modport master (
    output stall, branchsel, jump, jump_reg, halt, resume,
    output br_offset, jmp_offset, reg_target,
    input  pc, pc_next_seq, instr_valid, halted, redirect
  );

  modport slave (
    input  stall, branchsel, jump, jump_reg, halt, resume,
    input  br_offset, jmp_offset, reg_target,
    output pc, pc_next_seq, instr_valid, halted, redirect
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter stage with BOOT/RUN/HALT sequencing and next-PC selection.
// Optional branch/instruction counters are built when PC_BRANCH_STATS_EN is defined.
module pc_sequencer #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              INC      = 4
) (
  input  logic        clk,
  input  logic        rst,
  pc_seq_if.slave     bus
`ifdef PC_BRANCH_STATS_EN
  ,
  output logic [15:0] taken_cnt,
  output logic [15:0] instr_cnt
`endif
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  localparam logic [PC_W-1:0] INC_V      = PC_W'(INC);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~(INC_V - PC_W'(1));

  state_t          state_p1, state_d;
  logic [PC_W-1:0] pc_p1, pc_d, seq_pc;
  logic            redirect_p1, redirect_d;

  function automatic logic [PC_W-1:0] align(input logic [PC_W-1:0] a);
    return a & ALIGN_MASK;
  endfunction

  assign seq_pc = pc_p1 + INC_V;

  // Stage p1: architectural state register
  always_ff @(posedge clk) begin
    if (rst) state_p1 <= S_BOOT;
    else     state_p1 <= state_d;
  end

  always_comb begin
    state_d = state_p1;
    case (state_p1)
      S_BOOT: state_d = S_RUN;
      S_RUN:  if (!bus.stall && bus.halt) state_d = S_HALT;
      S_HALT: if (bus.resume) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  // Next-PC select; halt outranks every redirect request
  always_comb begin
    pc_d       = pc_p1;
    redirect_d = 1'b0;
    case (state_p1)
      S_RUN: begin
        if (!bus.stall && !bus.halt) begin
          if (bus.jump_reg) begin
            pc_d       = align(bus.reg_target);
            redirect_d = 1'b1;
          end else if (bus.jump) begin
            pc_d       = align(seq_pc + bus.jmp_offset);
            redirect_d = 1'b1;
          end else if (bus.branchsel) begin
            pc_d       = align(seq_pc + bus.br_offset);
            redirect_d = 1'b1;
          end else begin
            pc_d = seq_pc;
          end
        end
      end
      S_HALT: if (bus.resume) pc_d = seq_pc;
      default: pc_d = pc_p1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p1       <= RESET_PC;
      redirect_p1 <= 1'b0;
    end else begin
      pc_p1       <= pc_d;
      redirect_p1 <= redirect_d;
    end
  end

  assign bus.pc          = pc_p1;
  assign bus.pc_next_seq = seq_pc;
  assign bus.instr_valid = (state_p1 == S_RUN);
  assign bus.halted      = (state_p1 == S_HALT);
  assign bus.redirect    = redirect_p1;

`ifdef PC_BRANCH_STATS_EN
  logic run_go, taken;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign run_go = (state_p1 == S_RUN) && !bus.stall;
  assign taken  = run_go && !bus.halt && !bus.jump_reg && !bus.jump && bus.branchsel;

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (run_go) instr_cnt <= sat_inc(instr_cnt);
      if (taken)  taken_cnt <= sat_inc(taken_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; counter checks build when PC_BRANCH_STATS_EN is defined.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  pc_seq_if #(.PC_W(32)) bus ();

`ifdef PC_BRANCH_STATS_EN
  logic [15:0] taken_cnt, instr_cnt;
`endif

  pc_sequencer #(.PC_W(32), .RESET_PC(32'h0000_0000), .INC(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef PC_BRANCH_STATS_EN
    ,
    .taken_cnt(taken_cnt),
    .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.branchsel = 0; bus.jump = 0; bus.jump_reg = 0;
    bus.halt = 0; bus.resume = 0;
    bus.br_offset = '0; bus.jmp_offset = '0; bus.reg_target = '0;
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc,
                             input logic iv, input logic hl, input logic rd);
    check({tag, ".pc"}, bus.pc, pc);
    check({tag, ".iv"}, {31'd0, bus.instr_valid}, {31'd0, iv});
    check({tag, ".halted"}, {31'd0, bus.halted}, {31'd0, hl});
    check({tag, ".redirect"}, {31'd0, bus.redirect}, {31'd0, rd});
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    step(); step();
    check_state("reset", 32'h0, 0, 0, 0);
    check("reset.seq", bus.pc_next_seq, 32'h4);

    // BOOT is the state held across the first edge after release
    rst = 0;
    step();
    check_state("boot_exit", 32'h0, 1, 0, 0);
    step(); check_state("seq1", 32'h4, 1, 0, 0);
    step(); check_state("seq2", 32'h8, 1, 0, 0);
    step(); check_state("seq3", 32'hC, 1, 0, 0);
    step(); check_state("seq4", 32'h10, 1, 0, 0);

    // Backward branch
    bus.branchsel = 1; bus.br_offset = 32'hFFFF_FFF0;
    step(); check_state("br_back", 32'h4, 1, 0, 1);
    bus.branchsel = 0;
    step(); check_state("br_after", 32'h8, 1, 0, 0);

    repeat (6) step();
    check("reach20", bus.pc, 32'h20);

    // jump_reg wins over jump and branch, low bits cleared
    bus.jump_reg = 1; bus.jump = 1; bus.branchsel = 1;
    bus.reg_target = 32'h0000_0103; bus.jmp_offset = 32'h40; bus.br_offset = 32'h80;
    step(); check_state("jr_prio", 32'h100, 1, 0, 1);
    idle_inputs();

    bus.jump_reg = 1; bus.reg_target = 32'h40;
    step(); check("to40", bus.pc, 32'h40);
    idle_inputs();

    // Stall holds pc even with a branch pending
    bus.stall = 1; bus.branchsel = 1; bus.br_offset = 32'h8;
    for (int i = 0; i < 3; i++) begin
      step(); check_state("stall", 32'h40, 1, 0, 0);
    end
    bus.stall = 0;
    step(); check_state("stall_rel", 32'h4C, 1, 0, 1);
    idle_inputs();

    // Jump over branch, unaligned offset masked
    bus.jump = 1; bus.branchsel = 1; bus.jmp_offset = 32'h22; bus.br_offset = 32'h100;
    step(); check_state("jump", 32'h70, 1, 0, 1);
    idle_inputs();
    bus.jump_reg = 1; bus.reg_target = 32'h50;
    step(); check("to50", bus.pc, 32'h50);
    idle_inputs();

    // Halt beats branch; everything but resume ignored while halted
    bus.halt = 1; bus.branchsel = 1; bus.br_offset = 32'h20;
    step(); check_state("halt_in", 32'h50, 0, 1, 0);
    bus.stall = 1; bus.jump = 1; bus.jump_reg = 1; bus.reg_target = 32'h200;
    for (int i = 0; i < 4; i++) begin
      step(); check_state("halted", 32'h50, 0, 1, 0);
    end
    idle_inputs();
    bus.resume = 1;
    step(); check_state("resume", 32'h54, 1, 0, 0);
    bus.resume = 0;
    check("resume.seq", bus.pc_next_seq, 32'h58);

    bus.halt = 1;
    step(); check_state("halt2", 32'h54, 0, 1, 0);
    bus.halt = 0;
    rst = 1;
    step(); check_state("rst_in_halt", 32'h0, 0, 0, 0);
    rst = 0;
    step(); check_state("rst_boot", 32'h0, 1, 0, 0);

    // Wrap-around
    bus.jump_reg = 1; bus.reg_target = 32'hFFFF_FFFC;
    step(); check("wrap_pre", bus.pc, 32'hFFFF_FFFC);
    check("wrap_seq", bus.pc_next_seq, 32'h0);
    idle_inputs();
    step(); check_state("wrap", 32'h0, 1, 0, 0);

    // Stall ignored during BOOT
    rst = 1; step();
    rst = 0; bus.stall = 1;
    step(); check_state("boot_stall", 32'h0, 1, 0, 0);
    step(); check("stall_run", bus.pc, 32'h0);
    bus.stall = 0;
    step(); check("stall_run_rel", bus.pc, 32'h4);

`ifdef PC_BRANCH_STATS_EN
    rst = 1; step();
    check("cnt_rst_taken", {16'd0, taken_cnt}, 32'd0);
    check("cnt_rst_instr", {16'd0, instr_cnt}, 32'd0);
    rst = 0;
    step();
    bus.br_offset = 32'h0;
    for (int i = 0; i < 10; i++) begin
      bus.branchsel = (i == 1 || i == 4 || i == 7);
      step();
    end
    bus.branchsel = 0;
    // Stalled cycle and jump-over-branch cycle: only the latter retires
    bus.stall = 1; bus.branchsel = 1;
    step();
    bus.stall = 0; bus.jump = 1;
    step();
    idle_inputs();
    check("taken_cnt", {16'd0, taken_cnt}, 32'd3);
    check("instr_cnt", {16'd0, instr_cnt}, 32'd11);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
